// File: rtl/flipper_axi_pkg.sv
// Shared AXI-Lite definitions: master FSM state encoding, response codes and
// a response-classification helper used by cpu_axil_master.
package flipper_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_RD_ADDR     = 3'd1,
        ST_RD_DATA     = 3'd2,
        ST_WR_ADDRDATA = 3'd3,
        ST_WR_RESP     = 3'd4
    } axil_state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    // SLVERR and DECERR are the only error codes; equivalent to resp[1].
    function automatic logic axi_resp_is_err(input logic [1:0] resp);
        return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
    endfunction

endpackage

// File: rtl/cpu_axil_master.sv
// Simple CPU request port to AXI-Lite master bridge, one transaction at a time.
// Optional one-entry request buffer enabled by macro CPU_AXIL_MASTER_REQ_BUF_EN.
module cpu_axil_master
    import flipper_axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  ReqRead,
    input  logic                  ReqWrite,
    input  logic [ADDR_WIDTH-1:0] ReqAddress,
    input  logic [31:0]           ReqWriteData,
    input  logic [3:0]            ReqWriteStrobe,
    output logic                  ReqReady,
    output logic                  RespValid,
    output logic [31:0]           RespReadData,
    output logic                  RespError,

    output logic [ADDR_WIDTH-1:0] araddr_m,
    output logic [2:0]            arprot_m,
    output logic                  arvalid_m,
    input  logic                  arready_m,
    input  logic [31:0]           rdata_m,
    input  logic [1:0]            rresp_m,
    input  logic                  rvalid_m,
    output logic                  rready_m,

    output logic [ADDR_WIDTH-1:0] awaddr_m,
    output logic [2:0]            awprot_m,
    output logic                  awvalid_m,
    input  logic                  awready_m,
    output logic [31:0]           wdata_m,
    output logic [3:0]            wstrb_m,
    output logic                  wvalid_m,
    input  logic                  wready_m,
    input  logic [1:0]            bresp_m,
    input  logic                  bvalid_m,
    output logic                  bready_m
);

    axil_state_e           state_r, state_nx_s;

    logic [ADDR_WIDTH-1:0] araddr_r, araddr_nx_s;
    logic                  arvalid_r, arvalid_nx_s;
    logic                  rready_r, rready_nx_s;
    logic [ADDR_WIDTH-1:0] awaddr_r, awaddr_nx_s;
    logic                  awvalid_r, awvalid_nx_s;
    logic [31:0]           wdata_r, wdata_nx_s;
    logic [3:0]            wstrb_r, wstrb_nx_s;
    logic                  wvalid_r, wvalid_nx_s;
    logic                  bready_r, bready_nx_s;
    logic                  resp_valid_r, resp_valid_nx_s;
    logic                  resp_error_r, resp_error_nx_s;
    logic [31:0]           resp_rdata_r, resp_rdata_nx_s;

    logic                  aw_done_s;
    logic                  w_done_s;

    logic                  req_ready_s;
    logic                  launch_s;
    logic                  launch_write_s;
    logic [ADDR_WIDTH-1:0] launch_addr_s;
    logic [31:0]           launch_wdata_s;
    logic [3:0]            launch_wstrb_s;

`ifdef CPU_AXIL_MASTER_REQ_BUF_EN
    logic                  req_fire_s;
    logic                  buf_valid_r;
    logic                  buf_write_r;
    logic [ADDR_WIDTH-1:0] buf_addr_r;
    logic [31:0]           buf_wdata_r;
    logic [3:0]            buf_wstrb_r;

    // Request acceptance and launch source: a buffered request wins in IDLE.
    always_comb begin
        req_ready_s    = ~buf_valid_r & ~reset;
        req_fire_s     = req_ready_s & (ReqRead | ReqWrite);
        launch_s       = 1'b0;
        launch_write_s = 1'b0;
        launch_addr_s  = {ADDR_WIDTH{1'b0}};
        launch_wdata_s = 32'h0000_0000;
        launch_wstrb_s = 4'h0;
        if (state_r == ST_IDLE) begin
            if (buf_valid_r) begin
                launch_s       = 1'b1;
                launch_write_s = buf_write_r;
                launch_addr_s  = buf_addr_r;
                launch_wdata_s = buf_wdata_r;
                launch_wstrb_s = buf_wstrb_r;
            end else if (req_fire_s) begin
                launch_s       = 1'b1;
                launch_write_s = ReqWrite;
                launch_addr_s  = ReqAddress;
                launch_wdata_s = ReqWriteData;
                launch_wstrb_s = ReqWriteStrobe;
            end else begin
                launch_s = 1'b0;
            end
        end else begin
            launch_s = 1'b0;
        end
    end

    // One-entry buffer: filled by a request accepted while busy, drained in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid_r <= 1'b0;
            buf_write_r <= 1'b0;
            buf_addr_r  <= {ADDR_WIDTH{1'b0}};
            buf_wdata_r <= 32'h0000_0000;
            buf_wstrb_r <= 4'h0;
        end else if (req_fire_s && (state_r != ST_IDLE)) begin
            buf_valid_r <= 1'b1;
            buf_write_r <= ReqWrite;
            buf_addr_r  <= ReqAddress;
            buf_wdata_r <= ReqWriteData;
            buf_wstrb_r <= ReqWriteStrobe;
        end else if ((state_r == ST_IDLE) && buf_valid_r) begin
            buf_valid_r <= 1'b0;
        end else begin
            buf_valid_r <= buf_valid_r;
        end
    end
`else
    // Request acceptance: only in IDLE, launching straight from the request port.
    always_comb begin
        req_ready_s    = (state_r == ST_IDLE) & ~reset;
        launch_s       = req_ready_s & (ReqRead | ReqWrite);
        launch_write_s = ReqWrite;
        launch_addr_s  = ReqAddress;
        launch_wdata_s = ReqWriteData;
        launch_wstrb_s = ReqWriteStrobe;
    end
`endif

    // Next-state and next-output logic for the transaction FSM.
    always_comb begin
        state_nx_s      = state_r;
        araddr_nx_s     = araddr_r;
        arvalid_nx_s    = arvalid_r;
        rready_nx_s     = rready_r;
        awaddr_nx_s     = awaddr_r;
        awvalid_nx_s    = awvalid_r;
        wdata_nx_s      = wdata_r;
        wstrb_nx_s      = wstrb_r;
        wvalid_nx_s     = wvalid_r;
        bready_nx_s     = bready_r;
        resp_valid_nx_s = 1'b0;
        resp_error_nx_s = resp_error_r;
        resp_rdata_nx_s = resp_rdata_r;
        aw_done_s       = 1'b0;
        w_done_s        = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (launch_s && launch_write_s) begin
                    state_nx_s   = ST_WR_ADDRDATA;
                    awaddr_nx_s  = launch_addr_s;
                    wdata_nx_s   = launch_wdata_s;
                    wstrb_nx_s   = launch_wstrb_s;
                    awvalid_nx_s = 1'b1;
                    wvalid_nx_s  = 1'b1;
                end else if (launch_s) begin
                    state_nx_s   = ST_RD_ADDR;
                    araddr_nx_s  = launch_addr_s;
                    arvalid_nx_s = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end

            ST_RD_ADDR: begin
                if (arvalid_r && arready_m) begin
                    state_nx_s   = ST_RD_DATA;
                    arvalid_nx_s = 1'b0;
                    rready_nx_s  = 1'b1;
                end else begin
                    state_nx_s = ST_RD_ADDR;
                end
            end

            ST_RD_DATA: begin
                if (rready_r && rvalid_m) begin
                    state_nx_s      = ST_IDLE;
                    rready_nx_s     = 1'b0;
                    resp_valid_nx_s = 1'b1;
                    resp_rdata_nx_s = rdata_m;
                    resp_error_nx_s = axi_resp_is_err(rresp_m);
                end else begin
                    state_nx_s = ST_RD_DATA;
                end
            end

            ST_WR_ADDRDATA: begin
                // AW and W complete independently; a channel already done stays done.
                aw_done_s = ~awvalid_r | awready_m;
                w_done_s  = ~wvalid_r | wready_m;
                if (awvalid_r && awready_m) begin
                    awvalid_nx_s = 1'b0;
                end else begin
                    awvalid_nx_s = awvalid_r;
                end
                if (wvalid_r && wready_m) begin
                    wvalid_nx_s = 1'b0;
                end else begin
                    wvalid_nx_s = wvalid_r;
                end
                if (aw_done_s && w_done_s) begin
                    state_nx_s  = ST_WR_RESP;
                    bready_nx_s = 1'b1;
                end else begin
                    state_nx_s = ST_WR_ADDRDATA;
                end
            end

            ST_WR_RESP: begin
                if (bready_r && bvalid_m) begin
                    state_nx_s      = ST_IDLE;
                    bready_nx_s     = 1'b0;
                    resp_valid_nx_s = 1'b1;
                    resp_error_nx_s = axi_resp_is_err(bresp_m);
                end else begin
                    state_nx_s = ST_WR_RESP;
                end
            end

            default: begin
                state_nx_s   = ST_IDLE;
                arvalid_nx_s = 1'b0;
                rready_nx_s  = 1'b0;
                awvalid_nx_s = 1'b0;
                wvalid_nx_s  = 1'b0;
                bready_nx_s  = 1'b0;
            end
        endcase
    end

    // State and registered output updates; reset abandons any transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            araddr_r     <= {ADDR_WIDTH{1'b0}};
            arvalid_r    <= 1'b0;
            rready_r     <= 1'b0;
            awaddr_r     <= {ADDR_WIDTH{1'b0}};
            awvalid_r    <= 1'b0;
            wdata_r      <= 32'h0000_0000;
            wstrb_r      <= 4'h0;
            wvalid_r     <= 1'b0;
            bready_r     <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_error_r <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
        end else begin
            state_r      <= state_nx_s;
            araddr_r     <= araddr_nx_s;
            arvalid_r    <= arvalid_nx_s;
            rready_r     <= rready_nx_s;
            awaddr_r     <= awaddr_nx_s;
            awvalid_r    <= awvalid_nx_s;
            wdata_r      <= wdata_nx_s;
            wstrb_r      <= wstrb_nx_s;
            wvalid_r     <= wvalid_nx_s;
            bready_r     <= bready_nx_s;
            resp_valid_r <= resp_valid_nx_s;
            resp_error_r <= resp_error_nx_s;
            resp_rdata_r <= resp_rdata_nx_s;
        end
    end

    assign ReqReady     = req_ready_s;
    assign RespValid    = resp_valid_r;
    assign RespReadData = resp_rdata_r;
    assign RespError    = resp_error_r;

    assign araddr_m  = araddr_r;
    assign arprot_m  = AXI_PROT_DEFAULT;
    assign arvalid_m = arvalid_r;
    assign rready_m  = rready_r;
    assign awaddr_m  = awaddr_r;
    assign awprot_m  = AXI_PROT_DEFAULT;
    assign awvalid_m = awvalid_r;
    assign wdata_m   = wdata_r;
    assign wstrb_m   = wstrb_r;
    assign wvalid_m  = wvalid_r;
    assign bready_m  = bready_r;

endmodule

// File: tb/tb_cpu_axil_master.sv
// Directed self-checking bench for cpu_axil_master; the slave side is driven
// cycle by cycle from each scenario task.
module tb_cpu_axil_master;

`ifdef CPU_AXIL_MASTER_REQ_BUF_EN
    localparam bit BUF_EN = 1'b1;
`else
    localparam bit BUF_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        ReqRead, ReqWrite;
    logic [31:0] ReqAddress, ReqWriteData;
    logic [3:0]  ReqWriteStrobe;
    logic        ReqReady, RespValid, RespError;
    logic [31:0] RespReadData;
    logic [31:0] araddr_m, awaddr_m, rdata_m, wdata_m;
    logic [2:0]  arprot_m, awprot_m;
    logic        arvalid_m, arready_m, rvalid_m, rready_m;
    logic        awvalid_m, awready_m, wvalid_m, wready_m, bvalid_m, bready_m;
    logic [1:0]  rresp_m, bresp_m;
    logic [3:0]  wstrb_m;

    int pass_cnt = 0;
    int total_cnt = 0;

    cpu_axil_master #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .ReqRead(ReqRead), .ReqWrite(ReqWrite), .ReqAddress(ReqAddress),
        .ReqWriteData(ReqWriteData), .ReqWriteStrobe(ReqWriteStrobe),
        .ReqReady(ReqReady), .RespValid(RespValid), .RespReadData(RespReadData),
        .RespError(RespError),
        .araddr_m(araddr_m), .arprot_m(arprot_m), .arvalid_m(arvalid_m), .arready_m(arready_m),
        .rdata_m(rdata_m), .rresp_m(rresp_m), .rvalid_m(rvalid_m), .rready_m(rready_m),
        .awaddr_m(awaddr_m), .awprot_m(awprot_m), .awvalid_m(awvalid_m), .awready_m(awready_m),
        .wdata_m(wdata_m), .wstrb_m(wstrb_m), .wvalid_m(wvalid_m), .wready_m(wready_m),
        .bresp_m(bresp_m), .bvalid_m(bvalid_m), .bready_m(bready_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total_cnt++; if (ReqReady !== 1'b0) $display("FAIL rst_reqready: got %b want 0", ReqReady); else pass_cnt++;
        total_cnt++; if ({arvalid_m, awvalid_m, wvalid_m} !== 3'b000) $display("FAIL rst_valids: got %b want 000", {arvalid_m, awvalid_m, wvalid_m}); else pass_cnt++;
        total_cnt++; if ({rready_m, bready_m} !== 2'b00) $display("FAIL rst_readies: got %b want 00", {rready_m, bready_m}); else pass_cnt++;
        total_cnt++; if ({RespValid, RespError} !== 2'b00) $display("FAIL rst_resp: got %b want 00", {RespValid, RespError}); else pass_cnt++;
        total_cnt++; if (RespReadData !== 32'h0) $display("FAIL rst_rdata: got %h want 00000000", RespReadData); else pass_cnt++;
        total_cnt++; if ({arprot_m, awprot_m} !== 6'b0) $display("FAIL rst_prot: got %b want 000000", {arprot_m, awprot_m}); else pass_cnt++;
        reset = 1'b0;
        tick();
        total_cnt++; if (ReqReady !== 1'b1) $display("FAIL rst_release_reqready: got %b want 1", ReqReady); else pass_cnt++;
    endtask

    task automatic test_write_zero_wait();
        ReqAddress = 32'h0C00_4004; ReqWriteData = 32'hDEAD_BEEF; ReqWriteStrobe = 4'hF;
        ReqWrite = 1'b1; awready_m = 1'b1; wready_m = 1'b1;
        total_cnt++; if (ReqReady !== 1'b1) $display("FAIL wr_accept: got %b want 1", ReqReady); else pass_cnt++;
        tick(); // N+1
        ReqWrite = 1'b0;
        total_cnt++; if ({awvalid_m, wvalid_m} !== 2'b11) $display("FAIL wr_valids_n1: got %b want 11", {awvalid_m, wvalid_m}); else pass_cnt++;
        total_cnt++; if (awaddr_m !== 32'h0C00_4004) $display("FAIL wr_awaddr: got %h want 0c004004", awaddr_m); else pass_cnt++;
        total_cnt++; if (wdata_m !== 32'hDEAD_BEEF) $display("FAIL wr_wdata: got %h want deadbeef", wdata_m); else pass_cnt++;
        total_cnt++; if (wstrb_m !== 4'hF) $display("FAIL wr_wstrb: got %h want f", wstrb_m); else pass_cnt++;
        total_cnt++; if (ReqReady !== BUF_EN) $display("FAIL wr_busy_reqready: got %b want %b", ReqReady, BUF_EN); else pass_cnt++;
        tick(); // N+2
        total_cnt++; if ({awvalid_m, wvalid_m, bready_m} !== 3'b001) $display("FAIL wr_n2: got aw/w/b %b want 001", {awvalid_m, wvalid_m, bready_m}); else pass_cnt++;
        total_cnt++; if (RespValid !== 1'b0) $display("FAIL wr_early_resp: got %b want 0", RespValid); else pass_cnt++;
        bvalid_m = 1'b1; bresp_m = 2'b00;
        tick(); // N+3
        bvalid_m = 1'b0; awready_m = 1'b0; wready_m = 1'b0;
        total_cnt++; if ({RespValid, RespError} !== 2'b10) $display("FAIL wr_resp_n3: got valid/err %b want 10", {RespValid, RespError}); else pass_cnt++;
        total_cnt++; if (RespReadData !== 32'h0) $display("FAIL wr_rdata_kept: got %h want 00000000", RespReadData); else pass_cnt++;
        total_cnt++; if (bready_m !== 1'b0) $display("FAIL wr_bready_drop: got %b want 0", bready_m); else pass_cnt++;
        tick();
        total_cnt++; if (RespValid !== 1'b0) $display("FAIL wr_resp_pulse: got %b want 0", RespValid); else pass_cnt++;
    endtask

    task automatic test_read_stall();
        ReqAddress = 32'h0C00_2000; ReqRead = 1'b1; arready_m = 1'b0;
        tick(); // N+1
        ReqRead = 1'b0;
        // stray slave strobes that must be ignored while in RD_ADDR
        rvalid_m = 1'b1; rdata_m = 32'hBAD0_BAD0; rresp_m = 2'b11; bvalid_m = 1'b1;
        total_cnt++; if (araddr_m !== 32'h0C00_2000) $display("FAIL rd_araddr: got %h want 0c002000", araddr_m); else pass_cnt++;
        total_cnt++; if (arvalid_m !== 1'b1) $display("FAIL rd_arvalid_stall0: got %b want 1", arvalid_m); else pass_cnt++;
        for (int i = 1; i < 5; i++) begin
            tick();
            total_cnt++; if ({arvalid_m, rready_m, RespValid} !== 3'b100) $display("FAIL rd_stall%0d: got ar/r/resp %b want 100", i, {arvalid_m, rready_m, RespValid}); else pass_cnt++;
        end
        tick(); // N+6
        rvalid_m = 1'b0; bvalid_m = 1'b0; arready_m = 1'b1;
        total_cnt++; if (arvalid_m !== 1'b1) $display("FAIL rd_arvalid_n6: got %b want 1", arvalid_m); else pass_cnt++;
        tick(); // N+7
        arready_m = 1'b0;
        total_cnt++; if ({arvalid_m, rready_m} !== 2'b01) $display("FAIL rd_data_phase: got ar/r %b want 01", {arvalid_m, rready_m}); else pass_cnt++;
        rvalid_m = 1'b1; rdata_m = 32'h1234_5678; rresp_m = 2'b00;
        tick(); // N+8
        rvalid_m = 1'b0;
        total_cnt++; if ({RespValid, RespError} !== 2'b10) $display("FAIL rd_resp: got valid/err %b want 10", {RespValid, RespError}); else pass_cnt++;
        total_cnt++; if (RespReadData !== 32'h1234_5678) $display("FAIL rd_rdata: got %h want 12345678", RespReadData); else pass_cnt++;
        tick();
        total_cnt++; if ({RespValid, rready_m} !== 2'b00) $display("FAIL rd_after: got resp/r %b want 00", {RespValid, rready_m}); else pass_cnt++;
    endtask

    task automatic test_write_split();
        ReqAddress = 32'h0C00_4008; ReqWriteData = 32'hA5A5_0F0F; ReqWriteStrobe = 4'b0011;
        ReqWrite = 1'b1; awready_m = 1'b0; wready_m = 1'b1;
        tick(); // N+1: W handshake
        ReqWrite = 1'b0;
        total_cnt++; if ({awvalid_m, wvalid_m} !== 2'b11) $display("FAIL split_n1: got aw/w %b want 11", {awvalid_m, wvalid_m}); else pass_cnt++;
        tick(); // N+2
        wready_m = 1'b0;
        total_cnt++; if ({awvalid_m, wvalid_m, bready_m} !== 3'b100) $display("FAIL split_wdrop: got aw/w/b %b want 100", {awvalid_m, wvalid_m, bready_m}); else pass_cnt++;
        tick(); // N+3
        total_cnt++; if ({awvalid_m, bready_m} !== 2'b10) $display("FAIL split_n3: got aw/b %b want 10", {awvalid_m, bready_m}); else pass_cnt++;
        tick(); // N+4: AW handshake
        awready_m = 1'b1;
        total_cnt++; if ({awvalid_m, bready_m} !== 2'b10) $display("FAIL split_n4: got aw/b %b want 10", {awvalid_m, bready_m}); else pass_cnt++;
        tick(); // N+5
        awready_m = 1'b0;
        total_cnt++; if ({awvalid_m, wvalid_m, bready_m} !== 3'b001) $display("FAIL split_wrresp: got aw/w/b %b want 001", {awvalid_m, wvalid_m, bready_m}); else pass_cnt++;
        bvalid_m = 1'b1; bresp_m = 2'b10;
        tick(); // N+6
        bvalid_m = 1'b0; bresp_m = 2'b00;
        total_cnt++; if ({RespValid, RespError} !== 2'b11) $display("FAIL split_slverr: got valid/err %b want 11", {RespValid, RespError}); else pass_cnt++;
        total_cnt++; if (RespReadData !== 32'h1234_5678) $display("FAIL split_rdata_kept: got %h want 12345678", RespReadData); else pass_cnt++;
        tick();
    endtask

    task automatic test_read_write_same();
        ReqAddress = 32'h0C00_6000; ReqWriteData = 32'h0000_00FF; ReqWriteStrobe = 4'b0001;
        ReqRead = 1'b1; ReqWrite = 1'b1; awready_m = 1'b1; wready_m = 1'b1; arready_m = 1'b1;
        tick(); // N+1
        ReqRead = 1'b0; ReqWrite = 1'b0;
        total_cnt++; if ({awvalid_m, wvalid_m, arvalid_m} !== 3'b110) $display("FAIL both_n1: got aw/w/ar %b want 110", {awvalid_m, wvalid_m, arvalid_m}); else pass_cnt++;
        tick(); // N+2
        total_cnt++; if ({bready_m, arvalid_m} !== 2'b10) $display("FAIL both_n2: got b/ar %b want 10", {bready_m, arvalid_m}); else pass_cnt++;
        bvalid_m = 1'b1; bresp_m = 2'b00;
        tick(); // N+3
        bvalid_m = 1'b0; awready_m = 1'b0; wready_m = 1'b0;
        total_cnt++; if ({RespValid, RespError} !== 2'b10) $display("FAIL both_resp: got valid/err %b want 10", {RespValid, RespError}); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++; if ({arvalid_m, RespValid} !== 2'b00) $display("FAIL both_no_ar%0d: got ar/resp %b want 00", i, {arvalid_m, RespValid}); else pass_cnt++;
        end
        arready_m = 1'b0;
    endtask

    task automatic test_reset_mid();
        ReqAddress = 32'h0C00_3000; ReqRead = 1'b1; arready_m = 1'b1;
        tick(); // N+1
        ReqRead = 1'b0;
        total_cnt++; if (arvalid_m !== 1'b1) $display("FAIL rstmid_ar: got %b want 1", arvalid_m); else pass_cnt++;
        tick(); // N+2: RD_DATA
        arready_m = 1'b0;
        total_cnt++; if (rready_m !== 1'b1) $display("FAIL rstmid_rready: got %b want 1", rready_m); else pass_cnt++;
        reset = 1'b1; rvalid_m = 1'b1; rdata_m = 32'hFFFF_0000; rresp_m = 2'b00;
        #1;
        total_cnt++; if (ReqReady !== 1'b0) $display("FAIL rstmid_reqready: got %b want 0", ReqReady); else pass_cnt++;
        tick(); // N+3
        total_cnt++; if ({arvalid_m, rready_m, RespValid} !== 3'b000) $display("FAIL rstmid_clear: got ar/r/resp %b want 000", {arvalid_m, rready_m, RespValid}); else pass_cnt++;
        total_cnt++; if (RespReadData !== 32'h0) $display("FAIL rstmid_rdata: got %h want 00000000", RespReadData); else pass_cnt++;
        reset = 1'b0;
        tick();
        total_cnt++; if ({RespValid, rready_m, ReqReady} !== 3'b001) $display("FAIL rstmid_after: got resp/r/ready %b want 001", {RespValid, rready_m, ReqReady}); else pass_cnt++;
        rvalid_m = 1'b0;
        tick();
        total_cnt++; if (RespValid !== 1'b0) $display("FAIL rstmid_noresp: got %b want 0", RespValid); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        ReqAddress = 32'h0C00_5000; ReqWriteData = 32'h1122_3344; ReqWriteStrobe = 4'hF;
        ReqWrite = 1'b1; awready_m = 1'b1; wready_m = 1'b1;
        tick(); // N+1: write busy, offer a read
        ReqWrite = 1'b0; ReqRead = 1'b1; ReqAddress = 32'h0C00_5004;
        total_cnt++; if (ReqReady !== BUF_EN) $display("FAIL b2b_ready_busy: got %b want %b", ReqReady, BUF_EN); else pass_cnt++;
        tick(); // N+2
        ReqRead = 1'b0; awready_m = 1'b0; wready_m = 1'b0; arready_m = 1'b1;
        total_cnt++; if ({bready_m, arvalid_m} !== 2'b10) $display("FAIL b2b_n2: got b/ar %b want 10", {bready_m, arvalid_m}); else pass_cnt++;
        if (BUF_EN) begin
            total_cnt++; if (ReqReady !== 1'b0) $display("FAIL b2b_buf_full: got %b want 0", ReqReady); else pass_cnt++;
        end
        bvalid_m = 1'b1; bresp_m = 2'b00;
        tick(); // N+3
        bvalid_m = 1'b0;
        total_cnt++; if ({RespValid, arvalid_m} !== 2'b10) $display("FAIL b2b_wresp: got resp/ar %b want 10", {RespValid, arvalid_m}); else pass_cnt++;
        tick(); // N+4
        total_cnt++; if (arvalid_m !== BUF_EN) $display("FAIL b2b_ar_issue: got %b want %b", arvalid_m, BUF_EN); else pass_cnt++;
        if (BUF_EN) begin
            total_cnt++; if (araddr_m !== 32'h0C00_5004) $display("FAIL b2b_araddr: got %h want 0c005004", araddr_m); else pass_cnt++;
            tick(); // N+5
            arready_m = 1'b0;
            total_cnt++; if (rready_m !== 1'b1) $display("FAIL b2b_rready: got %b want 1", rready_m); else pass_cnt++;
            rvalid_m = 1'b1; rdata_m = 32'hCAFE_F00D; rresp_m = 2'b00;
            tick(); // N+6
            rvalid_m = 1'b0;
            total_cnt++; if ({RespValid, RespReadData} !== {1'b1, 32'hCAFE_F00D}) $display("FAIL b2b_rresp: got %b/%h want 1/cafef00d", RespValid, RespReadData); else pass_cnt++;
        end
        arready_m = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; ReqRead = 1'b0; ReqWrite = 1'b0;
        ReqAddress = 32'h0; ReqWriteData = 32'h0; ReqWriteStrobe = 4'h0;
        arready_m = 1'b0; rvalid_m = 1'b0; rdata_m = 32'h0; rresp_m = 2'b00;
        awready_m = 1'b0; wready_m = 1'b0; bvalid_m = 1'b0; bresp_m = 2'b00;
        test_reset();
        test_write_zero_wait();
        test_read_stall();
        test_write_split();
        test_read_write_same();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
